// File: rtl/y_alu.sv
`default_nettype none
// ============================================================================
// Module  : y_alu
// Brief   : 32-bit AND/OR/ADD/SUB/SLT ALU with ripple-carry adder, zero and
//           signed-overflow flags, plus a registered copy of all outputs.
// Revision: 1.0 - initial release
// ============================================================================
module y_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] z,
   output logic             ex,
   output logic             ovf,
   output logic [WIDTH-1:0] z_q,
   output logic             ex_q,
   output logic             ovf_q
);

   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_slt;
   logic [WIDTH-1:0] w_mux;
   logic             w_add_ovf;
   logic             w_valid;

   // op[2] turns the shared adder into a subtractor: invert b, carry in 1.
   assign w_bx   = b ^ {WIDTH{op[2]}};
   assign w_c[0] = op[2];

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_fa
         assign w_sum[i] = a[i] ^ w_bx[i] ^ w_c[i];
         if (i < WIDTH - 1) begin : g_carry
            assign w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
         end
      end
   endgenerate

   // Same sign on both adder inputs but a different sign on the sum.
   assign w_add_ovf = ~(a[WIDTH-1] ^ w_bx[WIDTH-1]) & (w_sum[WIDTH-1] ^ a[WIDTH-1]);
   assign w_slt     = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};

   always_comb begin
      w_mux = '0;
      case (op[1:0])
         2'b00:   w_mux = a & b;
         2'b01:   w_mux = a | b;
         2'b10:   w_mux = w_sum;
         default: w_mux = w_slt;
      endcase
   end

   assign w_valid = (op == 3'b000) | (op == 3'b001) | (op == 3'b010) |
                    (op == 3'b110) | (op == 3'b111);

   assign z   = w_valid ? w_mux : '0;
   assign ex  = ~|z;
   assign ovf = w_add_ovf & op[1] & ~op[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z_q   <= '0;
         ex_q  <= 1'b1;
         ovf_q <= 1'b0;
      end else begin
         z_q   <= z;
         ex_q  <= ex;
         ovf_q <= ovf;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_y_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_y_alu
// Brief   : Scoreboard bench for y_alu combinational and registered outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_y_alu;

   typedef struct packed {
      logic [31:0] z;
      logic        ex;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic [31:0] z;
   logic        ex;
   logic        ovf;
   logic [31:0] z_q;
   logic        ex_q;
   logic        ovf_q;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t cq[$];
   exp_t rq[$];

   y_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .op    (op),
      .z     (z),
      .ex    (ex),
      .ovf   (ovf),
      .z_q   (z_q),
      .ex_q  (ex_q),
      .ovf_q (ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [2:0] mop);
      exp_t   e;
      longint s;
      e.z   = 32'h0;
      e.ovf = 1'b0;
      case (mop)
         3'b000: e.z = ma & mb;
         3'b001: e.z = ma | mb;
         3'b010: begin
            s     = longint'($signed(ma)) + longint'($signed(mb));
            e.z   = s[31:0];
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b110: begin
            s     = longint'($signed(ma)) - longint'($signed(mb));
            e.z   = s[31:0];
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b111: e.z = ($signed(ma) < $signed(mb)) ? 32'h1 : 32'h0;
         default: e.z = 32'h0;
      endcase
      e.ex = (e.z == 32'h0);
      return e;
   endfunction

   task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic [2:0] dop);
      a  = da;
      b  = db;
      op = dop;
      cq.push_back(model(da, db, dop));
      rq.push_back(model(da, db, dop));
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      drive(32'd3, 32'd4, 3'b010);
      #1;
      n_tests++;
      if ({z_q, ex_q, ovf_q} !== {32'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_regs: got z_q=%h ex_q=%b ovf_q=%b want 0/1/0", z_q, ex_q, ovf_q);
      end
      e = cq.pop_front();
      void'(rq.pop_front());
      n_tests++;
      if ({z, ex, ovf} !== e) begin
         n_fail++;
         $display("FAIL comb_in_reset: got %h/%b/%b want %h/%b/%b", z, ex, ovf, e.z, e.ex, e.ovf);
      end
   endtask

   // Directed combinational vectors: logic, add wrap/overflow, sub, slt, unused ops.
   task automatic test_directed();
      logic [31:0] va [16] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h7FFFFFFF,
                               32'h00000005, 32'h12345678, 32'h00000000, 32'h80000000,
                               32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h12345678,
                               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000};
      logic [31:0] vb [16] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'h00000001, 32'h00000001,
                               32'h00000007, 32'h12345678, 32'h00000001, 32'h00000001,
                               32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678,
                               32'h12345678, 32'h12345678, 32'h12345678, 32'h80000000};
      logic [2:0]  vo [16] = '{3'b000, 3'b001, 3'b010, 3'b010,
                               3'b110, 3'b110, 3'b110, 3'b110,
                               3'b111, 3'b111, 3'b111, 3'b111,
                               3'b011, 3'b100, 3'b101, 3'b010};
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         drive(va[i], vb[i], vo[i]);
         void'(rq.pop_front());
         #1;
         e = cq.pop_front();
         n_tests++;
         if ({z, ex, ovf} !== e) begin
            n_fail++;
            $display("FAIL directed[%0d] op=%b a=%h b=%h: got %h/%b/%b want %h/%b/%b",
                     i, vo[i], va[i], vb[i], z, ex, ovf, e.z, e.ex, e.ovf);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
      exp_t e;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 12; i++) begin
            drive($urandom, $urandom, ops[k]);
            void'(rq.pop_front());
            #1;
            e = cq.pop_front();
            n_tests++;
            if ({z, ex, ovf} !== e) begin
               n_fail++;
               $display("FAIL random op=%b a=%h b=%h: got %h/%b/%b want %h/%b/%b",
                        ops[k], a, b, z, ex, ovf, e.z, e.ex, e.ovf);
            end
         end
      end
   endtask

   task automatic test_registered();
      exp_t e;
      cq.delete();
      rq.delete();
      @(negedge clk);
      reset = 1'b0;
      drive(32'd3, 32'd4, 3'b010);
      @(posedge clk);
      #1;
      e = rq.pop_front();
      n_tests++;
      if ({z_q, ex_q, ovf_q} !== e || z_q !== 32'd7) begin
         n_fail++;
         $display("FAIL reg_first: got %h/%b/%b want %h/%b/%b", z_q, ex_q, ovf_q, e.z, e.ex, e.ovf);
      end
      // Back-to-back cycles, including an overflowing add and a zero result.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         case (i)
            0:       drive(32'h7FFFFFFF, 32'h1, 3'b010);
            1:       drive(32'h0, 32'h0, 3'b001);
            default: drive($urandom, $urandom, 3'($urandom_range(0, 7)));
         endcase
         @(posedge clk);
         #1;
         e = rq.pop_front();
         n_tests++;
         if ({z_q, ex_q, ovf_q} !== e) begin
            n_fail++;
            $display("FAIL reg_b2b[%0d]: got %h/%b/%b want %h/%b/%b",
                     i, z_q, ex_q, ovf_q, e.z, e.ex, e.ovf);
         end
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if ({z_q, ex_q, ovf_q} !== {32'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reg_async_reset: got %h/%b/%b want 0/1/0", z_q, ex_q, ovf_q);
      end
      drive(32'h7FFFFFFF, 32'h1, 3'b010);
      void'(rq.pop_front());
      @(posedge clk);
      #1;
      n_tests++;
      if ({z_q, ex_q, ovf_q} !== {32'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reg_reset_hold: got %h/%b/%b want 0/1/0", z_q, ex_q, ovf_q);
      end
      @(negedge clk);
      reset = 1'b0;
      drive(32'h80000000, 32'h1, 3'b110);
      @(posedge clk);
      #1;
      e = rq.pop_front();
      n_tests++;
      if ({z_q, ex_q, ovf_q} !== e) begin
         n_fail++;
         $display("FAIL reg_after_release: got %h/%b/%b want %h/%b/%b",
                  z_q, ex_q, ovf_q, e.z, e.ex, e.ovf);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish within limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      a     = '0;
      b     = '0;
      op    = '0;
      test_reset();
      test_directed();
      test_random();
      test_registered();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
